// File: rtl/mpu401_pkg.sv
// MPU-401 receive controller shared constants and types.
// Optional build macro: MPU401_ACTIVE_SENSE_FILTER_EN.
package mpu401_pkg;

  localparam logic [7:0] CMD_RESET      = 8'hFF;
  localparam logic [7:0] CMD_UART       = 8'h3F;
  localparam logic [7:0] MPU_ACK        = 8'hFE;
  localparam logic [7:0] MIDI_ACT_SENSE = 8'hFE;
  localparam logic [7:0] MIDI_CLOCK     = 8'hF8;

  typedef enum logic {
    MODE_INTEL,
    MODE_UART
  } mode_t;

endpackage

// File: rtl/mpu401_byte_fifo.sv
// Synchronous byte FIFO with flush and a registered head copy.
// Pointers carry one extra wrap bit to tell full from empty.
module mpu401_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  input  logic       flush,
  output logic       empty,
  output logic       full,
  output logic [7:0] dout
);

  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0] head;
  logic do_push;
  logic do_pop;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // a pop frees the slot the same cycle, so push+pop is legal when full
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // an empty FIFO leaves the last byte visible on dout
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (!empty) begin
      dout <= head;
    end
  end

endmodule

// File: rtl/mpu401_rx_ctrl.sv
// MPU-401 receive side: command decode, ACK/MIDI arbitration, FIFO, IRQ.
// Build macro MPU401_ACTIVE_SENSE_FILTER_EN drops 0xFE/0xF8 in UART mode.
module mpu401_rx_ctrl
  import mpu401_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_byte,
  input  logic       data_rd,
  output logic [7:0] data_out,
  output logic [7:0] status_out,
  output logic       irq,
  output logic       uart_mode,
  output logic       overflow
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  mode_t mode, mode_nxt;
  logic ack_pending, ack_nxt;
  logic hold_valid, hold_v_nxt;
  logic [7:0] hold_byte, hold_b_nxt;
  logic ovf_nxt;

  logic empty, full;
  logic cmd_reset, rx_filt, rx_take;
  logic can_push, ack_push, hold_push, hold_lost;
  logic fifo_push;
  logic [7:0] fifo_din;

`ifdef MPU401_ACTIVE_SENSE_FILTER_EN
  assign rx_filt = (rx_byte == MIDI_ACT_SENSE) ||
                   (rx_byte == MIDI_CLOCK);
`else
  assign rx_filt = 1'b0;
`endif

  assign cmd_reset = cmd_wr && (cmd_byte == CMD_RESET);
  assign rx_take   = rx_valid && (mode == MODE_UART) && !rx_filt;

  // ACK beats the held MIDI byte; a held byte with no room is lost
  assign can_push  = !full || (data_rd && !empty);
  assign ack_push  = ack_pending && can_push;
  assign hold_push = hold_valid && !ack_pending && can_push;
  assign hold_lost = hold_valid && !can_push;
  assign fifo_push = ack_push || hold_push;
  assign fifo_din  = ack_push ? MPU_ACK : hold_byte;

  always_comb begin
    mode_nxt   = mode;
    ack_nxt    = ack_pending && !ack_push;
    hold_v_nxt = hold_valid && !hold_push && !hold_lost;
    hold_b_nxt = hold_byte;
    ovf_nxt    = overflow || hold_lost;
    if (rx_take) begin
      ovf_nxt    = ovf_nxt || hold_v_nxt;
      hold_v_nxt = 1'b1;
      hold_b_nxt = rx_byte;
    end
    if (cmd_wr) begin
      unique case (mode)
        MODE_INTEL: begin
          ack_nxt = 1'b1;
          if (cmd_byte == CMD_UART) begin
            mode_nxt = MODE_UART;
          end
        end
        MODE_UART: begin
          if (cmd_reset) begin
            mode_nxt = MODE_INTEL;
            ack_nxt  = 1'b0;
          end
        end
      endcase
    end
    if (cmd_reset) begin
      hold_v_nxt = 1'b0;
      ovf_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode        <= MODE_INTEL;
      ack_pending <= 1'b0;
      hold_valid  <= 1'b0;
      hold_byte   <= '0;
      overflow    <= 1'b0;
      irq         <= 1'b0;
    end else begin
      mode        <= mode_nxt;
      ack_pending <= ack_nxt;
      hold_valid  <= hold_v_nxt;
      hold_byte   <= hold_b_nxt;
      overflow    <= ovf_nxt;
      irq         <= !empty;
    end
  end

  mpu401_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (data_rd),
    .flush (cmd_reset),
    .empty (empty),
    .full  (full),
    .dout  (data_out)
  );

  assign uart_mode  = (mode == MODE_UART);
  assign status_out = {empty, 1'b0, 6'b111111};

endmodule

// File: tb/tb_mpu401_rx_ctrl.sv
// Bench for mpu401_rx_ctrl: vector table, directed corners, random vs model.
// Honours MPU401_ACTIVE_SENSE_FILTER_EN like the design.
module tb_mpu401_rx_ctrl;

  localparam int DEPTH = 16;
`ifdef MPU401_ACTIVE_SENSE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic rx_valid;
  logic [7:0] rx_byte;
  logic cmd_wr;
  logic [7:0] cmd_byte;
  logic data_rd;
  logic [7:0] data_out;
  logic [7:0] status_out;
  logic irq;
  logic uart_mode;
  logic overflow;

  int n_chk = 0;
  int n_fail = 0;

  mpu401_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .cmd_wr     (cmd_wr),
    .cmd_byte   (cmd_byte),
    .data_rd    (data_rd),
    .data_out   (data_out),
    .status_out (status_out),
    .irq        (irq),
    .uart_mode  (uart_mode),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // reference model: byte queue plus mode/ack/hold flags
  logic [7:0] q[$];
  bit m_uart, m_ack, m_hv, m_ovf, m_irq;
  logic [7:0] m_hb, m_dout;

  function automatic bit filt(input logic [7:0] b);
    return FILT && (b == 8'hFE || b == 8'hF8);
  endfunction

  task automatic model_step();
    bit ne, pop, room, wr_ack, wr_hold, lost, fl;
    logic [7:0] wv;
    if (reset) begin
      q.delete();
      m_uart = 0; m_ack = 0; m_hv = 0; m_hb = 0;
      m_ovf = 0; m_irq = 0; m_dout = 0;
      return;
    end
    ne = q.size() > 0;
    if (ne) m_dout = q[0];
    m_irq = ne;
    pop = data_rd && ne;
    room = (q.size() < DEPTH) || pop;
    wr_ack = m_ack && room;
    wr_hold = m_hv && !m_ack && room;
    lost = m_hv && !room;
    wv = wr_ack ? 8'hFE : m_hb;
    if (wr_ack) m_ack = 0;
    if (wr_hold || lost) m_hv = 0;
    if (lost) m_ovf = 1;
    if (rx_valid && m_uart && !filt(rx_byte)) begin
      if (m_hv) m_ovf = 1;
      m_hv = 1;
      m_hb = rx_byte;
    end
    fl = cmd_wr && cmd_byte == 8'hFF;
    if (cmd_wr && !m_uart) begin
      m_ack = 1;
      if (cmd_byte == 8'h3F) m_uart = 1;
    end else if (fl) begin
      m_uart = 0;
      m_ack = 0;
    end
    if (fl) begin
      m_hv = 0;
      m_ovf = 0;
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (wr_ack || wr_hold) q.push_back(wv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input bit rv, input logic [7:0] rb,
                     input bit cw, input logic [7:0] cb,
                     input bit rd);
    rx_valid = rv; rx_byte = rb;
    cmd_wr = cw; cmd_byte = cb;
    data_rd = rd;
    tick();
    rx_valid = 0; cmd_wr = 0; data_rd = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 8'h00, 0, 8'h00, 0);
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit rv; logic [7:0] rb;
    bit cw; logic [7:0] cb;
    bit rd;
    bit e_irq; bit e_uart;
    logic [7:0] e_st; logic [7:0] e_do;
  } vec_t;

  function automatic vec_t mk(bit rv, logic [7:0] rb, bit cw,
                              logic [7:0] cb, bit rd, bit ei,
                              bit eu, logic [7:0] es,
                              logic [7:0] ed);
    vec_t v;
    v.rv = rv; v.rb = rb; v.cw = cw; v.cb = cb; v.rd = rd;
    v.e_irq = ei; v.e_uart = eu; v.e_st = es; v.e_do = ed;
    return v;
  endfunction

  vec_t tbl[22];
  logic [7:0] exp_q[$];

  initial begin
    tbl[0]  = mk(0, 8'h00, 1, 8'h3F, 0, 0, 1, 8'hBF, 8'h00);
    tbl[1]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h3F, 8'h00);
    tbl[2]  = mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 8'h3F, 8'hFE);
    tbl[3]  = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 8'hBF, 8'hFE);
    tbl[4]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'hBF, 8'hFE);
    tbl[5]  = mk(1, 8'h90, 0, 8'h00, 0, 0, 1, 8'hBF, 8'hFE);
    tbl[6]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h3F, 8'hFE);
    tbl[7]  = mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 8'h3F, 8'h90);
    tbl[8]  = mk(1, 8'h3C, 0, 8'h00, 0, 1, 1, 8'h3F, 8'h90);
    tbl[9]  = mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 8'h3F, 8'h90);
    tbl[10] = mk(1, 8'h7F, 0, 8'h00, 0, 1, 1, 8'h3F, 8'h90);
    tbl[11] = mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 8'h3F, 8'h90);
    tbl[12] = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 8'h3F, 8'h90);
    tbl[13] = mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 8'h3F, 8'h3C);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 8'h3F, 8'h3C);
    tbl[15] = mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 8'h3F, 8'h7F);
    tbl[16] = mk(0, 8'h00, 0, 8'h00, 1, 1, 1, 8'hBF, 8'h7F);
    tbl[17] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'hBF, 8'h7F);
    tbl[18] = mk(0, 8'h00, 1, 8'hFF, 0, 0, 0, 8'hBF, 8'h7F);
    tbl[19] = mk(1, 8'h90, 0, 8'h00, 0, 0, 0, 8'hBF, 8'h7F);
    tbl[20] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'hBF, 8'h7F);
    tbl[21] = mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 8'hBF, 8'h7F);

    rx_valid = 0; rx_byte = 0; cmd_wr = 0; cmd_byte = 0;
    data_rd = 0;
    reset = 1;
    idle(2);
    reset = 0;
    chk("rst_status", status_out, 8'hBF);
    chk("rst_irq", irq, 0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_uart", uart_mode, 0);
    chk("rst_ovf", overflow, 0);

    // vector table: ack, three UART bytes, back to INTEL
    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].rv, tbl[i].rb, tbl[i].cw, tbl[i].cb, tbl[i].rd);
      chk($sformatf("vec%0d_irq", i), irq, tbl[i].e_irq);
      chk($sformatf("vec%0d_uart", i), uart_mode, tbl[i].e_uart);
      chk($sformatf("vec%0d_st", i), status_out, tbl[i].e_st);
      chk($sformatf("vec%0d_do", i), data_out, tbl[i].e_do);
      chk($sformatf("vec%0d_ovf", i), overflow, 0);
    end

    // overflow: 17 bytes into a 16-deep FIFO
    cyc(0, 0, 1, 8'h3F, 0); idle(2);
    cyc(0, 0, 0, 0, 1); idle(1);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 8'(8'h10 + i), 0, 0, 0);
      if (i == 0) chk("lat_e0_irq", irq, 0);
      idle(1);
      if (i == 0) begin
        chk("lat_e1_irq", irq, 0);
        idle(1);
        chk("lat_e2_irq", irq, 1);
      end
    end
    idle(1);
    chk("ovf_set", overflow, 1);
    chk("ovf_full_st", status_out, 8'h3F);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_rd%0d", i), data_out, 8'(8'h10 + i));
      cyc(0, 0, 0, 0, 1);
      idle(1);
    end
    chk("ovf_17_lost", status_out, 8'hBF);
    chk("ovf_sticky", overflow, 1);
    cyc(1, 8'h55, 0, 0, 0); idle(1);
    cyc(1, 8'h56, 0, 0, 0); idle(1);
    cyc(0, 0, 1, 8'hFF, 0);
    chk("uff_uart", uart_mode, 0);
    chk("uff_ovf", overflow, 0);
    chk("uff_st", status_out, 8'hBF);
    idle(3);
    chk("uff_noack", status_out, 8'hBF);
    chk("uff_irq", irq, 0);

    // flush with a coincident ACK push and rx_valid
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 8'h01, 0);
      idle(1);
    end
    cyc(0, 0, 1, 8'h01, 0);
    cyc(1, 8'h90, 1, 8'hFF, 0);
    chk("iff_flush_st", status_out, 8'hBF);
    idle(1);
    chk("iff_ack_st", status_out, 8'h3F);
    idle(2);
    chk("iff_do", data_out, 8'hFE);
    chk("iff_irq", irq, 1);
    chk("iff_uart", uart_mode, 0);
    cyc(0, 0, 0, 0, 1); idle(1);
    chk("iff_one", status_out, 8'hBF);

    // active-sense / clock filtering
    cyc(0, 0, 1, 8'h3F, 0); idle(2);
    cyc(0, 0, 0, 0, 1); idle(1);
    cyc(1, 8'hFE, 0, 0, 0); idle(1);
    cyc(1, 8'h90, 0, 0, 0); idle(1);
    cyc(1, 8'hF8, 0, 0, 0); idle(3);
    if (!FILT) exp_q.push_back(8'hFE);
    exp_q.push_back(8'h90);
    if (!FILT) exp_q.push_back(8'hF8);
    foreach (exp_q[i]) begin
      chk($sformatf("flt_rd%0d", i), data_out, exp_q[i]);
      cyc(0, 0, 0, 0, 1);
      idle(1);
    end
    chk("flt_empty", status_out, 8'hBF);
    chk("flt_ovf", overflow, 0);

    // random traffic against the model
    reset = 1;
    idle(2);
    reset = 0;
    begin
      bit prev_rx;
      prev_rx = 0;
      for (int i = 0; i < 3000; i++) begin
        bit rv, cw, rd;
        logic [7:0] rb, cb;
        int r, rd_pct;
        rd_pct = ((i / 200) % 2 == 1) ? 5 : 45;
        rv = !prev_rx && ($urandom_range(0, 99) < 40);
        r = $urandom_range(0, 7);
        rb = (r == 0) ? 8'hFE : (r == 1) ? 8'hF8 : 8'($urandom);
        cw = $urandom_range(0, 99) < 4;
        r = $urandom_range(0, 9);
        cb = (r == 0) ? 8'hFF : (r < 4) ? 8'h3F : 8'($urandom);
        rd = $urandom_range(0, 99) < rd_pct;
        cyc(rv, rb, cw, cb, rd);
        prev_rx = rv;
        chk($sformatf("rnd%0d_do", i), data_out, m_dout);
        chk($sformatf("rnd%0d_irq", i), irq, m_irq);
        chk($sformatf("rnd%0d_st", i), status_out,
            {q.size() == 0, 7'h3F});
        chk($sformatf("rnd%0d_uart", i), uart_mode, m_uart);
        chk($sformatf("rnd%0d_ovf", i), overflow, m_ovf);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
